// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Shares one 8-digit seven-segment bank between three requesters. Grants
//   one requester at a time in round-robin order, converts its value(s) to
//   two BCD digits with a serial double-dabble engine, then writes only that
//   requester's digit slots.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   req[2:0]     : update requests (0 = PC, 1 = register pair, 2 = print reg)
//   pc_val       : value for requester 0
//   rs_val/rt_val: value pair for requester 1
//   pr_val       : value for requester 2
//   ack[2:0]     : one-cycle completion pulse, aligned with new HEX values
//   busy         : high whenever the FSM is not in IDLE
//   HEX7..HEX0   : registered active-low segment outputs
//                  (HEX7/6 = rs, HEX5/4 = rt, HEX3/2 = PC, HEX1/0 = print)
module hex_display_scheduler #(
  parameter logic [6:0] OVF_PATTERN = 7'b0111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] pc_val,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] pr_val,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [6:0]  HEX7,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [3:0]      cnt_q, cnt_d;
  // {tens[3:0], units[3:0], binary[6:0]} double-dabble shift register
  logic [14:0]     sr_q, sr_d;
  logic [6:0]      rt_q, rt_d;
  logic [7:0]      rs_dig_q, rs_dig_d;
  logic            ovf_a_q, ovf_a_d;
  logic            ovf_b_q, ovf_b_d;
  logic [2:0]      ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [7:0][6:0] hex_q, hex_d;

  // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
  function automatic logic [14:0] dd_step(input logic [14:0] s);
    logic [3:0]  t;
    logic [3:0]  u;
    logic [14:0] tmp;
    t = s[14:11];
    u = s[10:7];
    if (t >= 4'd5) t = t + 4'd3;
    else           t = t;
    if (u >= 4'd5) u = u + 4'd3;
    else           u = u;
    tmp = {t, u, s[6:0]};
    return {tmp[13:0], 1'b0};
  endfunction

  // Active-low segment encoding of one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return OVF_PATTERN;
    endcase
  endfunction

  // Round-robin pick: search ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] o0, o1, o2;
    case (p)
      2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if      (r[o0]) return o0;
    else if (r[o1]) return o1;
    else            return o2;
  endfunction

  // Next-state, datapath and output-register computation.
  always_comb begin
    logic [1:0]  g;
    logic [14:0] step;
    logic [3:0]  last;
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    rt_d     = rt_q;
    rs_dig_d = rs_dig_q;
    ovf_a_d  = ovf_a_q;
    ovf_b_d  = ovf_b_q;
    ack_d    = 3'b000;
    hex_d    = hex_q;
    g        = rr_pick(req, ptr_q);
    step     = dd_step(sr_q);
    last     = (gnt_q == 2'd1) ? 4'd13 : 4'd6;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_d   = g;
          cnt_d   = 4'd0;
          ovf_b_d = 1'b0;
          rt_d    = 7'd0;
          case (g)
            2'd0: begin
              sr_d    = {8'd0, pc_val[6:0]};
              ovf_a_d = (pc_val > 32'd99);
            end
            2'd1: begin
              sr_d    = {8'd0, rs_val[6:0]};
              ovf_a_d = (rs_val > 32'd99);
              rt_d    = rt_val[6:0];
              ovf_b_d = (rt_val > 32'd99);
            end
            default: begin
              sr_d    = {8'd0, pr_val[6:0]};
              ovf_a_d = (pr_val > 32'd99);
            end
          endcase
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        // Pair requester: park rs digits after its 7th step, then start rt.
        if (gnt_q == 2'd1 && cnt_q == 4'd6) begin
          rs_dig_d = step[14:7];
          sr_d     = {8'd0, rt_q};
        end else begin
          sr_d     = step;
        end
        if (cnt_q == last) begin
          state_d = WRITE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      WRITE: begin
        case (gnt_q)
          2'd0: begin
            hex_d[3] = ovf_a_q ? OVF_PATTERN : seg7(sr_q[14:11]);
            hex_d[2] = ovf_a_q ? OVF_PATTERN : seg7(sr_q[10:7]);
          end
          2'd1: begin
            hex_d[7] = ovf_a_q ? OVF_PATTERN : seg7(rs_dig_q[7:4]);
            hex_d[6] = ovf_a_q ? OVF_PATTERN : seg7(rs_dig_q[3:0]);
            hex_d[5] = ovf_b_q ? OVF_PATTERN : seg7(sr_q[14:11]);
            hex_d[4] = ovf_b_q ? OVF_PATTERN : seg7(sr_q[10:7]);
          end
          default: begin
            hex_d[1] = ovf_a_q ? OVF_PATTERN : seg7(sr_q[14:11]);
            hex_d[0] = ovf_a_q ? OVF_PATTERN : seg7(sr_q[10:7]);
          end
        endcase
        // Registered here so the pulse coincides with DONE and the new digits.
        ack_d   = 3'b001 << gnt_q;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      gnt_q    <= 2'd0;
      cnt_q    <= 4'd0;
      sr_q     <= 15'd0;
      rt_q     <= 7'd0;
      rs_dig_q <= 8'd0;
      ovf_a_q  <= 1'b0;
      ovf_b_q  <= 1'b0;
      ack_q    <= 3'b000;
      busy_q   <= 1'b0;
      hex_q    <= {8{SEG_ZERO}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      rt_q     <= rt_d;
      rs_dig_q <= rs_dig_d;
      ovf_a_q  <= ovf_a_d;
      ovf_b_q  <= ovf_b_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      hex_q    <= hex_d;
    end
  end

  assign ack  = ack_q;
  assign busy = busy_q;
  assign HEX7 = hex_q[7];
  assign HEX6 = hex_q[6];
  assign HEX5 = hex_q[5];
  assign HEX4 = hex_q[4];
  assign HEX3 = hex_q[3];
  assign HEX2 = hex_q[2];
  assign HEX1 = hex_q[1];
  assign HEX0 = hex_q[0];

endmodule

// File: tb/tb_hex_display_scheduler.sv
module tb_hex_display_scheduler;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] OVF = 7'b0111111;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [31:0] pc_val, rs_val, rt_val, pr_val;
  logic [2:0]  ack;
  logic        busy;
  logic [6:0]  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [7:0][6:0] hex_all;
  logic [7:0][6:0] exp_hex;

  int n_checks = 0;
  int n_pass   = 0;

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  hex_display_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .pc_val(pc_val), .rs_val(rs_val), .rt_val(rt_val), .pr_val(pr_val),
    .ack(ack), .busy(busy),
    .HEX7(HEX7), .HEX6(HEX6), .HEX5(HEX5), .HEX4(HEX4),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request from IDLE, scramble inputs right after grant, and
  // check latency, ack value, ack width and busy behaviour.
  task automatic run_txn(input string tag, input logic [2:0] r,
                         input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pr,
                         input int exp_lat, input logic [2:0] exp_ack);
    int lat;
    int busy_low;
    bit seen;
    @(negedge clk);
    req = r; pc_val = pc; rs_val = rs; rt_val = rt; pr_val = pr;
    @(posedge clk);
    #1;
    req = 3'b000;
    pc_val = $urandom; rs_val = $urandom; rt_val = $urandom; pr_val = $urandom;
    lat = 1; seen = 1'b0; busy_low = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if (ack !== 3'b000) seen = 1'b1;
      else lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ack"}, 64'(ack), 64'(exp_ack));
    check({tag, "_busy_hi"}, 64'(busy_low), 64'd0);
    check({tag, "_hex"}, 64'(hex_all), 64'(exp_hex));
    @(negedge clk);
    check({tag, "_ack_w"}, 64'(ack), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int acks;
    logic [2:0] exp_order [4];
    rst_n = 1'b1; req = 3'b000;
    pc_val = 32'd0; rs_val = 32'd0; rt_val = 32'd0; pr_val = 32'd0;
    exp_hex = {8{S0}};

    do_reset();
    check("rst_hex", 64'(hex_all), 64'(exp_hex));
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    exp_hex[3] = S4; exp_hex[2] = S2;
    run_txn("pc42", 3'b001, 32'd42, 32'd0, 32'd0, 32'd0, 9, 3'b001);

    exp_hex[7] = S0; exp_hex[6] = S7; exp_hex[5] = S9; exp_hex[4] = S9;
    run_txn("pair7_99", 3'b010, 32'd0, 32'd7, 32'd99, 32'd0, 16, 3'b010);

    exp_hex[1] = OVF; exp_hex[0] = OVF;
    run_txn("pr100", 3'b100, 32'd0, 32'd0, 32'd0, 32'd100, 9, 3'b100);

    exp_hex[1] = S9; exp_hex[0] = S9;
    run_txn("pr99", 3'b100, 32'd0, 32'd0, 32'd0, 32'd99, 9, 3'b100);

    exp_hex[1] = OVF; exp_hex[0] = OVF;
    run_txn("prFFFF", 3'b100, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 9, 3'b100);

    exp_hex[1] = S9; exp_hex[0] = S9;
    run_txn("pr99b", 3'b100, 32'd0, 32'd0, 32'd0, 32'd99, 9, 3'b100);

    // Low 7 bits are 3, but the full value is over range.
    exp_hex[1] = OVF; exp_hex[0] = OVF;
    run_txn("pr131", 3'b100, 32'd0, 32'd0, 32'd0, 32'd131, 9, 3'b100);

    // Round-robin with all three requests held.
    do_reset();
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    req = 3'b111; pc_val = 32'd1; rs_val = 32'd2; rt_val = 32'd3; pr_val = 32'd4;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ack === 3'b000 && cyc < 40);
      check($sformatf("rr_ack%0d", k), 64'(ack), 64'(exp_order[k]));
      @(negedge clk);
      check($sformatf("rr_w%0d", k), 64'(ack), 64'd0);
      check($sformatf("rr_idle%0d", k), 64'(busy), 64'd0);
      if (k == 3) req = 3'b000;
      else begin
        @(negedge clk);
        check($sformatf("rr_busy%0d", k), 64'(busy), 64'd1);
      end
    end

    // Reset during CONV cycle 4 aborts the transaction.
    do_reset();
    @(negedge clk);
    req = 3'b001; pc_val = 32'd5;
    @(posedge clk);
    #1;
    req = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack !== 3'b000) acks++;
    end
    check("abort_noack", 64'(acks), 64'd0);
    exp_hex = {8{S0}};
    check("abort_hex", 64'(hex_all), 64'(exp_hex));
    exp_hex[3] = S0; exp_hex[2] = S5;
    run_txn("pc5", 3'b001, 32'd5, 32'd0, 32'd0, 32'd0, 9, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

Interface
REQ-001 SHALL have parameter OVF_PATTERN, default 7'b0111111 (dash); segment pattern shown on both digits of any value > 99.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous reset, active-low.
REQ-004 SHALL have port req, input, 3: update requests; bit0 = PC, bit1 = register pair, bit2 = print register.
REQ-005 SHALL have port pc_val, input, 32: PC value for requester 0.
REQ-006 SHALL have port rs_val, input, 32: first read register value for requester 1.
REQ-007 SHALL have port rt_val, input, 32: second read register value for requester 1.
REQ-008 SHALL have port pr_val, input, 32: print register value for requester 2.
REQ-009 SHALL have port ack, output, 3: one-cycle completion pulse per requester.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have ports HEX7..HEX0, output, 7 each: registered active-low seven-segment digits.

Function
REQ-012 SHALL use FSM states IDLE, CONV, WRITE, DONE.
REQ-013 IDLE: if req != 0, SHALL grant one requester by round-robin starting at pointer ptr, latch its value(s), load the iteration counter, and go to CONV.
REQ-014 Round-robin: ptr resets to 0; on DONE, ptr SHALL become (granted+1) mod 3; the search order is ptr, ptr+1, ptr+2 (mod 3).
REQ-015 CONV SHALL perform one shift-add-3 (double-dabble) step per cycle on the low 7 bits of the latched value: 7 cycles per value, giving tens and units BCD digits.
REQ-016 Requester 1 SHALL run CONV twice (rs_val, then rt_val): 14 CONV cycles; all others run 7.
REQ-017 Any latched value > 99 (full 32-bit compare) SHALL set an overflow flag; CONV still runs its full cycle count; both digits of that value are written as OVF_PATTERN.
REQ-018 WRITE (1 cycle) SHALL update only the granted slots: req0 -> HEX3 (tens), HEX2 (units); req1 -> HEX7/HEX6 (rs), HEX5/HEX4 (rt); req2 -> HEX1/HEX0. All other HEX registers hold.
REQ-019 Digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 DONE (1 cycle) SHALL assert ack[granted]=1 with the new HEX values already visible, advance ptr, then return to IDLE.
REQ-021 Latency: req seen in IDLE at cycle 0 -> ack at cycle 9 (req0/req2) or cycle 16 (req1); one grant at a time, with no preemption.
REQ-022 Inputs SHALL be sampled only at grant; changes to *_val or the deassertion of req after grant SHALL NOT affect the transaction in progress.
REQ-023 A requester SHALL drop req in the cycle after ack; a req still high at the next IDLE is treated as a new request, subject to round-robin.
REQ-024 A req deasserted before grant SHALL be ignored, with no ack.
REQ-025 Simultaneous requests SHALL be served in round-robin order, one per transaction, with no requester starved for more than 2 transactions.

Reset
REQ-026 When rst_n=0 at a rising edge, from any state, the block SHALL enter IDLE; ptr=0, ack=0, busy=0, counters/latches=0, all HEX7..HEX0=7'b1000000 ("0").
REQ-027 A reset during CONV, WRITE or DONE SHALL abort the transaction: no ack issued, and no partial HEX update survives.

Verification
REQ-028 Reset, then req=001, pc_val=42 -> ack[0] at cycle 9; HEX3=0011001, HEX2=0100100; others remain 1000000.
REQ-029 req=010, rs_val=7, rt_val=99 -> ack[1] at cycle 16; HEX7=1000000, HEX6=1111000, HEX5=HEX4=0010000.
REQ-030 req=100, pr_val=100 -> HEX1=HEX0=OVF_PATTERN; pr_val=32'hFFFF_FFFF -> same result.
REQ-031 req=111 held and re-asserted after each ack -> grant order 0,1,2,0; every ack is exactly one cycle wide; busy low only in IDLE cycles.
REQ-032 req=001, pc_val=5, with rst_n=0 at CONV cycle 4 -> no ack; HEX3/HEX2=1000000; after release, a new req=001 completes normally.
